// File: rtl/johnson_decoder_monitor.sv
// Johnson-code receive monitor: validates and decodes each sampled code,
// tracks successor order, declares lock after a good run, and counts sequence errors.
module johnson_decoder_monitor #(
    parameter int WIDTH      = 4,
    parameter int IDX_W      = 3,
    parameter int LOCK_COUNT = 3,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [WIDTH-1:0]     code,
    input  logic                 clr_err,
    output logic [IDX_W-1:0]     index,
    output logic                 idx_valid,
    output logic                 illegal,
    output logic                 seq_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int         NSTATES  = 2 * WIDTH;
    localparam logic [3:0] LOCK_RUN = 4'(LOCK_COUNT);

    // Johnson pattern for index k: k low ones up to WIDTH, then ones with k-WIDTH low zeros.
    function automatic logic [WIDTH-1:0] johnson_of(input int k);
        logic [WIDTH-1:0] c;
        c = '0;
        for (int b = 0; b < WIDTH; b++) begin
            c[b] = (k <= WIDTH) ? (b < k) : (b >= (k - WIDTH));
        end
        return c;
    endfunction

    // MSB of the result flags a legal code; the low IDX_W bits carry its index.
    function automatic logic [IDX_W:0] lookup(input logic [WIDTH-1:0] c);
        logic [IDX_W:0] r;
        r = '0;
        for (int k = 0; k < NSTATES; k++) begin
            r = (c == johnson_of(k)) ? {1'b1, IDX_W'(k)} : r;
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] succ(input logic [WIDTH-1:0] c);
        return {c[WIDTH-2:0], ~c[WIDTH-1]};
    endfunction

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       prev_q, prev_d;
    logic [3:0]             run_q, run_d;
    logic [IDX_W-1:0]       index_q, index_d;
    logic                   idx_valid_q, idx_valid_d;
    logic                   illegal_q, illegal_d;
    logic                   seq_err_q, seq_err_d;
    logic                   locked_q, locked_d;
    logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
    logic [IDX_W:0]         lk_s;
    logic                   legal_s;
    logic                   is_succ_s;

    // Next-state, decode and pulse generation for one en sample.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        run_d       = run_q;
        index_d     = index_q;
        idx_valid_d = 1'b0;
        illegal_d   = 1'b0;
        seq_err_d   = 1'b0;
        lk_s        = lookup(code);
        legal_s     = lk_s[IDX_W];
        is_succ_s   = (code == succ(prev_q));

        if (en) begin
            illegal_d   = ~legal_s;
            idx_valid_d = legal_s;
            index_d     = legal_s ? lk_s[IDX_W-1:0] : index_q;
            case (state_q)
                ST_SEARCH: begin
                    if (legal_s) begin
                        state_d = ST_TRACK;
                        prev_d  = code;
                        run_d   = 4'd0;
                    end else begin
                        state_d = ST_SEARCH;
                    end
                end
                ST_TRACK: begin
                    if (!legal_s) begin
                        state_d = ST_SEARCH;
                    end else if (is_succ_s) begin
                        run_d   = run_q + 4'd1;
                        prev_d  = code;
                        state_d = (run_d == LOCK_RUN) ? ST_LOCKED : ST_TRACK;
                    end else begin
                        run_d  = 4'd0;
                        prev_d = code;
                    end
                end
                ST_LOCKED: begin
                    // prev is always legal, so a successor match implies a legal code.
                    if (is_succ_s) begin
                        prev_d = code;
                    end else begin
                        seq_err_d = 1'b1;
                        if (legal_s) begin
                            state_d = ST_TRACK;
                            run_d   = 4'd0;
                            prev_d  = code;
                        end else begin
                            state_d = ST_SEARCH;
                        end
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        locked_d = (state_d == ST_LOCKED);

        if (clr_err) begin
            err_count_d = seq_err_d ? ERR_CNT_W'(1) : '0;
        end else if (seq_err_d && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_SEARCH;
            prev_q      <= '0;
            run_q       <= 4'd0;
            index_q     <= '0;
            idx_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            locked_q    <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            run_q       <= run_d;
            index_q     <= index_d;
            idx_valid_q <= idx_valid_d;
            illegal_q   <= illegal_d;
            seq_err_q   <= seq_err_d;
            locked_q    <= locked_d;
            err_count_q <= err_count_d;
        end
    end

    assign index     = index_q;
    assign idx_valid = idx_valid_q;
    assign illegal   = illegal_q;
    assign seq_err   = seq_err_q;
    assign locked    = locked_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_johnson_decoder_monitor.sv
// Scoreboard bench: directed Johnson vectors with hand-computed responses, checked
// by a negedge monitor against an 8-bit and a 2-bit error-counter instance.
module tb_johnson_decoder_monitor;

    logic       clk, reset, en, clr_err;
    logic [3:0] code;
    logic [2:0] index, index2;
    logic       idx_valid, illegal, seq_err, locked;
    logic       idx_valid2, illegal2, seq_err2, locked2;
    logic [7:0] err_count;
    logic [1:0] err_count2;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic [2:0] idx;
        logic [3:0] flags;   // {idx_valid, illegal, seq_err, locked}
        logic [7:0] e8;
        logic [1:0] e2;
        int         due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_x;

    johnson_decoder_monitor #(.WIDTH(4), .IDX_W(3), .LOCK_COUNT(3), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .code(code), .clr_err(clr_err),
        .index(index), .idx_valid(idx_valid), .illegal(illegal), .seq_err(seq_err),
        .locked(locked), .err_count(err_count));

    johnson_decoder_monitor #(.WIDTH(4), .IDX_W(3), .LOCK_COUNT(3), .ERR_CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .code(code), .clr_err(clr_err),
        .index(index2), .idx_valid(idx_valid2), .illegal(illegal2), .seq_err(seq_err2),
        .locked(locked2), .err_count(err_count2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Issue one vector and queue the response expected after the next edge.
    task automatic step(input logic e, input logic [3:0] c, input logic clr,
                        input logic [2:0] xi, input logic [3:0] xf,
                        input logic [7:0] xe8, input logic [1:0] xe2);
        exp_t x;
        @(posedge clk);
        #2;
        en = e; code = c; clr_err = clr;
        x.idx = xi; x.flags = xf; x.e8 = xe8; x.e2 = xe2; x.due = cyc + 1;
        sb.push_back(x);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".index"}, {5'd0, index}, 8'd0);
        chk({tag, ".flags"}, {4'd0, idx_valid, illegal, seq_err, locked}, 8'd0);
        chk({tag, ".err"}, err_count, 8'd0);
        chk({tag, ".err_sat"}, {6'd0, err_count2}, 8'd0);
    endtask

    // Monitor: pops every expectation whose sampling edge has passed.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                mon_x = sb.pop_front();
                chk("index", {5'd0, index}, {5'd0, mon_x.idx});
                chk("idx_valid", {7'd0, idx_valid}, {7'd0, mon_x.flags[3]});
                chk("illegal", {7'd0, illegal}, {7'd0, mon_x.flags[2]});
                chk("seq_err", {7'd0, seq_err}, {7'd0, mon_x.flags[1]});
                chk("locked", {7'd0, locked}, {7'd0, mon_x.flags[0]});
                chk("err_count", err_count, mon_x.e8);
                chk("err_count_sat", {6'd0, err_count2}, {6'd0, mon_x.e2});
            end
        end
    end

    initial begin
        reset = 1'b1; en = 1'b0; code = 4'b0000; clr_err = 1'b0;
        #1;
        chk_all_zero("reset_state");
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Lock and decode
        step(1'b1, 4'b0000, 1'b0, 3'd0, 4'b1000, 8'd0, 2'd0);
        step(1'b1, 4'b0001, 1'b0, 3'd1, 4'b1000, 8'd0, 2'd0);
        step(1'b1, 4'b0011, 1'b0, 3'd2, 4'b1000, 8'd0, 2'd0);
        step(1'b1, 4'b0111, 1'b0, 3'd3, 4'b1001, 8'd0, 2'd0);
        // Full wrap
        step(1'b1, 4'b1111, 1'b0, 3'd4, 4'b1001, 8'd0, 2'd0);
        step(1'b1, 4'b1110, 1'b0, 3'd5, 4'b1001, 8'd0, 2'd0);
        step(1'b1, 4'b1100, 1'b0, 3'd6, 4'b1001, 8'd0, 2'd0);
        step(1'b1, 4'b1000, 1'b0, 3'd7, 4'b1001, 8'd0, 2'd0);
        step(1'b1, 4'b0000, 1'b0, 3'd0, 4'b1001, 8'd0, 2'd0);
        // Illegal while locked, then re-lock
        step(1'b1, 4'b0101, 1'b0, 3'd0, 4'b0110, 8'd1, 2'd1);
        step(1'b1, 4'b0001, 1'b0, 3'd1, 4'b1000, 8'd1, 2'd1);
        step(1'b1, 4'b0011, 1'b0, 3'd2, 4'b1000, 8'd1, 2'd1);
        step(1'b1, 4'b0111, 1'b0, 3'd3, 4'b1000, 8'd1, 2'd1);
        step(1'b1, 4'b1111, 1'b0, 3'd4, 4'b1001, 8'd1, 2'd1);
        step(1'b1, 4'b1110, 1'b0, 3'd5, 4'b1001, 8'd1, 2'd1);
        step(1'b1, 4'b1100, 1'b0, 3'd6, 4'b1001, 8'd1, 2'd1);
        step(1'b1, 4'b1000, 1'b0, 3'd7, 4'b1001, 8'd1, 2'd1);
        step(1'b1, 4'b0000, 1'b0, 3'd0, 4'b1001, 8'd1, 2'd1);
        step(1'b1, 4'b0001, 1'b0, 3'd1, 4'b1001, 8'd1, 2'd1);
        step(1'b1, 4'b0011, 1'b0, 3'd2, 4'b1001, 8'd1, 2'd1);
        // Skip while locked: 0011 -> 1111
        step(1'b1, 4'b1111, 1'b0, 3'd4, 4'b1010, 8'd2, 2'd2);
        step(1'b1, 4'b1110, 1'b0, 3'd5, 4'b1000, 8'd2, 2'd2);
        step(1'b1, 4'b1100, 1'b0, 3'd6, 4'b1000, 8'd2, 2'd2);
        step(1'b1, 4'b1000, 1'b0, 3'd7, 4'b1001, 8'd2, 2'd2);
        // en gap with garbage on the bus
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0101, 1'b0, 3'd7, 4'b0001, 8'd2, 2'd2);
        step(1'b1, 4'b0000, 1'b0, 3'd0, 4'b1001, 8'd2, 2'd2);
        // Repeated code is a sequence error; small counter saturates
        step(1'b1, 4'b0000, 1'b0, 3'd0, 4'b1010, 8'd3, 2'd3);
        step(1'b1, 4'b0001, 1'b0, 3'd1, 4'b1000, 8'd3, 2'd3);
        step(1'b1, 4'b0011, 1'b0, 3'd2, 4'b1000, 8'd3, 2'd3);
        step(1'b1, 4'b0111, 1'b0, 3'd3, 4'b1001, 8'd3, 2'd3);
        // clr_err coincident with seq_err
        step(1'b1, 4'b0111, 1'b1, 3'd3, 4'b1010, 8'd1, 2'd1);
        step(1'b1, 4'b1111, 1'b0, 3'd4, 4'b1000, 8'd1, 2'd1);
        step(1'b1, 4'b1110, 1'b0, 3'd5, 4'b1000, 8'd1, 2'd1);
        step(1'b1, 4'b1100, 1'b0, 3'd6, 4'b1001, 8'd1, 2'd1);
        step(1'b1, 4'b1100, 1'b0, 3'd6, 4'b1010, 8'd2, 2'd2);
        step(1'b1, 4'b1000, 1'b0, 3'd7, 4'b1000, 8'd2, 2'd2);
        step(1'b1, 4'b0000, 1'b0, 3'd0, 4'b1000, 8'd2, 2'd2);
        step(1'b1, 4'b0001, 1'b0, 3'd1, 4'b1001, 8'd2, 2'd2);
        step(1'b1, 4'b0110, 1'b0, 3'd1, 4'b0110, 8'd3, 2'd3);
        step(1'b1, 4'b0011, 1'b0, 3'd2, 4'b1000, 8'd3, 2'd3);
        step(1'b1, 4'b0111, 1'b0, 3'd3, 4'b1000, 8'd3, 2'd3);
        step(1'b1, 4'b1111, 1'b0, 3'd4, 4'b1000, 8'd3, 2'd3);
        step(1'b1, 4'b1110, 1'b0, 3'd5, 4'b1001, 8'd3, 2'd3);
        step(1'b1, 4'b1010, 1'b0, 3'd5, 4'b0110, 8'd4, 2'd3);
        // Illegal in SEARCH: no seq_err; then clr_err alone
        step(1'b1, 4'b1010, 1'b0, 3'd5, 4'b0100, 8'd4, 2'd3);
        step(1'b0, 4'b0000, 1'b1, 3'd5, 4'b0000, 8'd0, 2'd0);
        step(1'b1, 4'b0000, 1'b0, 3'd0, 4'b1000, 8'd0, 2'd0);
        step(1'b1, 4'b0001, 1'b0, 3'd1, 4'b1000, 8'd0, 2'd0);
        step(1'b1, 4'b0011, 1'b0, 3'd2, 4'b1000, 8'd0, 2'd0);
        step(1'b1, 4'b0111, 1'b0, 3'd3, 4'b1001, 8'd0, 2'd0);

        // Asynchronous reset between edges while locked
        @(posedge clk);
        @(negedge clk);
        #2;
        en = 1'b0;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        #2 reset = 1'b0;
        step(1'b1, 4'b1000, 1'b0, 3'd7, 4'b1000, 8'd0, 2'd0);
        step(1'b0, 4'b0000, 1'b0, 3'd7, 4'b0000, 8'd0, 2'd0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, required 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
